// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 16-bit main memory.
// Single-word writes and pipelined burst reads over a req/ack handshake.
module mem_access_ctrl #(
  parameter int MEM_DEPTH = 16384,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [3:0]  burst_len,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic        rvalid,
  output logic [15:0] rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t      state_q;
  logic [3:0]  rem_q;
  logic        first_q;
  logic        ack_q;
  logic        err_q;
  logic        rvalid_q;
  logic [15:0] rdata_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic        mem_we_q;

  logic [16:0] end_addr;
  logic [4:0]  blen1;
  logic        addr_bad;
  logic        rd_bad;
  logic        req_bad;

  // End address kept in 17 bits so a wrap past 0xFFFF still counts as out of range
  assign end_addr = {1'b0, addr} + {13'b0, burst_len};
  assign blen1    = {1'b0, burst_len} + 5'd1;
  assign addr_bad = {1'b0, addr} >= 17'(MEM_DEPTH);
  assign rd_bad   = (end_addr >= 17'(MEM_DEPTH))
                  || (blen1 > 5'(MAX_BURST));
  assign req_bad  = addr_bad || (!we && rd_bad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      first_q     <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (req_bad) begin
              state_q <= DONE;
            end else if (we) begin
              mem_addr_q  <= addr;
              mem_wdata_q <= wdata;
              mem_we_q    <= 1'b1;
              state_q     <= WRITE;
            end else begin
              mem_addr_q <= addr;
              mem_we_q   <= 1'b0;
              rem_q      <= burst_len;
              first_q    <= 1'b1;
              state_q    <= READ;
            end
          end
        end
        WRITE: begin
          mem_we_q <= 1'b0;
          ack_q    <= 1'b1;
          state_q  <= IDLE;
        end
        READ: begin
          first_q <= 1'b0;
          // Memory data lags the address by one edge, so skip the first edge
          if (!first_q) begin
            rdata_q  <= mem_rdata;
            rvalid_q <= 1'b1;
          end
          if (rem_q != 4'd0) begin
            mem_addr_q <= mem_addr_q + 16'd1;
            rem_q      <= rem_q - 4'd1;
          end else begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          rdata_q  <= mem_rdata;
          rvalid_q <= 1'b1;
          ack_q    <= 1'b1;
          state_q  <= IDLE;
        end
        DONE: begin
          ack_q   <= 1'b1;
          err_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign ack       = ack_q;
  assign err       = err_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: registered-read memory, cycle-indexed
// expectation model, and directed requests with literal checks.
module tb_mem_access_ctrl;

  localparam int DEPTH = 16384;
  localparam int MAXB  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [3:0]  burst_len = '0;
  logic        busy, ack, err, rvalid, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;

  mem_access_ctrl #(.MEM_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(rst_n), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .burst_len(burst_len),
    .busy(busy), .ack(ack), .err(err), .rvalid(rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[13:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[13:0]];
  end

  int vectors = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc++;

  logic [15:0] ref_mem [0:DEPTH-1];
  bit          e_busy [int];
  bit          e_ack [int];
  bit          e_err [int];
  bit          e_we [int];
  bit          e_rv [int];
  logic [15:0] e_rd [int];
  logic [15:0] e_wa [int];
  logic [15:0] e_wd [int];
  logic [15:0] e_ra [int];
  logic [15:0] last_rd = '0;
  logic [15:0] rv_q [$];

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  function automatic void clear_model();
    e_busy.delete(); e_ack.delete(); e_err.delete();
    e_we.delete(); e_rv.delete(); e_rd.delete();
    e_wa.delete(); e_wd.delete(); e_ra.delete();
    last_rd = '0;
  endfunction

  // Outcome of a request accepted at edge e, cycle e = interval after that edge
  function automatic void sched(input logic w, input logic [15:0] a,
                                input logic [15:0] d, input logic [3:0] bl,
                                input int e);
    int n;
    bit bad;
    n = int'(bl) + 1;
    bad = (int'(a) >= DEPTH)
       || (!w && ((int'(a) + int'(bl) >= DEPTH) || (n > MAXB)));
    if (bad) begin
      e_busy[e] = 1; e_ack[e+1] = 1; e_err[e+1] = 1;
    end else if (w) begin
      e_busy[e] = 1; e_we[e] = 1; e_wa[e] = a; e_wd[e] = d;
      e_ack[e+1] = 1;
      ref_mem[a[13:0]] = d;
    end else begin
      for (int i = 0; i <= n; i++) e_busy[e+i] = 1;
      for (int i = 0; i < n; i++) e_ra[e+i] = a + 16'(i);
      e_ra[e+n] = a + 16'(n - 1);
      for (int k = 0; k < n; k++) begin
        e_rv[e+k+2] = 1;
        e_rd[e+k+2] = ref_mem[(a + 16'(k)) & 16'h3FFF];
      end
      e_ack[e+n+1] = 1;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (e_rv.exists(cyc)) last_rd = e_rd[cyc];
      chk("busy", 16'(busy), 16'(e_busy.exists(cyc)));
      chk("ack", 16'(ack), 16'(e_ack.exists(cyc)));
      chk("err", 16'(err), 16'(e_err.exists(cyc)));
      chk("rvalid", 16'(rvalid), 16'(e_rv.exists(cyc)));
      chk("mem_we", 16'(mem_we), 16'(e_we.exists(cyc)));
      chk("rdata", rdata, last_rd);
      if (e_we.exists(cyc)) begin
        chk("wr_addr", mem_addr, e_wa[cyc]);
        chk("wr_data", mem_wdata, e_wd[cyc]);
      end
      if (e_ra.exists(cyc)) chk("rd_addr", mem_addr, e_ra[cyc]);
      if (rvalid) rv_q.push_back(rdata);
    end
  end

  task automatic do_req(input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [3:0] bl,
                        input bit poke, output int lat);
    int e, n;
    @(negedge clk);
    rv_q.delete();
    req = 1'b1; we = w; addr = a; wdata = d; burst_len = bl;
    e = cyc + 1;
    sched(w, a, d, bl, e);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!ack && n < 40) begin
      @(negedge clk);
      n++;
      if (poke && cyc == e + 2) begin
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'hDEAD;
      end else if (poke && cyc == e + 3) begin
        req = 1'b0;
      end
    end
    if (!ack) chk("ack_timeout", 16'd0, 16'd1);
    lat = cyc - e;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_ack"}, 16'(ack), 16'd0);
    chk({tag, "_err"}, 16'(err), 16'd0);
    chk({tag, "_rvalid"}, 16'(rvalid), 16'd0);
    chk({tag, "_rdata"}, rdata, 16'd0);
    chk({tag, "_mem_addr"}, mem_addr, 16'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 16'd0);
    chk({tag, "_mem_we"}, 16'(mem_we), 16'd0);
  endtask

  initial begin
    int lat, e;
    logic [15:0] bv [4];
    #2;
    chk_all_zero("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_req(1'b1, 16'h0010, 16'hBEEF, 4'd0, 1'b0, lat);
    chk("wr_lat", 16'(lat), 16'd1);
    chk("wr_mem", mem[16'h0010], 16'hBEEF);

    do_req(1'b0, 16'h0010, 16'h0000, 4'd0, 1'b0, lat);
    chk("rd1_lat", 16'(lat), 16'd2);
    chk("rd1_cnt", 16'(rv_q.size()), 16'd1);
    if (rv_q.size() > 0) chk("rd1_data", rv_q[0], 16'hBEEF);

    bv = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 16'h0100 + 16'(i), bv[i], 4'd0, 1'b0, lat);
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 16'h3FFC + 16'(i), 16'hA000 + 16'(i), 4'd0, 1'b0, lat);

    do_req(1'b0, 16'h0100, 16'h0000, 4'd3, 1'b1, lat);
    chk("burst_lat", 16'(lat), 16'd5);
    chk("burst_cnt", 16'(rv_q.size()), 16'd4);
    for (int i = 0; i < 4 && i < rv_q.size(); i++)
      chk("burst_data", rv_q[i], bv[i]);
    chk("poke_mem", mem[16'h0020], 16'h0000);

    do_req(1'b1, 16'h4000, 16'h1234, 4'd0, 1'b0, lat);
    chk("err_wr_lat", 16'(lat), 16'd1);
    do_req(1'b0, 16'h3FFE, 16'h0000, 4'd2, 1'b0, lat);
    chk("err_end_lat", 16'(lat), 16'd1);
    chk("err_end_cnt", 16'(rv_q.size()), 16'd0);
    do_req(1'b0, 16'h0000, 16'h0000, 4'd8, 1'b0, lat);
    chk("err_len_lat", 16'(lat), 16'd1);
    chk("err_mem", mem[16'h0000], 16'h0000);

    do_req(1'b0, 16'h3FFC, 16'h0000, 4'd3, 1'b0, lat);
    chk("edge_lat", 16'(lat), 16'd5);
    chk("edge_cnt", 16'(rv_q.size()), 16'd4);
    for (int i = 0; i < 4 && i < rv_q.size(); i++)
      chk("edge_data", rv_q[i], 16'hA000 + 16'(i));

    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 16'h0100; burst_len = 4'd7;
    e = cyc + 1;
    sched(1'b0, 16'h0100, 16'h0000, 4'd7, e);
    @(negedge clk);
    req = 1'b0;
    while (cyc < e + 3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 16'h0010, 16'h0000, 4'd0, 1'b0, lat);
    chk("post_lat", 16'(lat), 16'd2);
    chk("post_cnt", 16'(rv_q.size()), 16'd1);
    if (rv_q.size() > 0) chk("post_data", rv_q[0], 16'hBEEF);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
